// File: rtl/mem2_pkg.sv
// Shared definitions for the second memory stage: bus layouts, load/store size
// encodings, FSM state encoding, debug view and the drop-counter update rule.
package mem2_pkg;

    localparam int MEM12MEM2_BUS_SIZE = 76;
    localparam int MEM22WB_BUS_SIZE   = 70;

    // ld_st_size encodings carried in mem_control[2:0]
    localparam logic [2:0] LS_SIZE_B = 3'd4;
    localparam logic [2:0] LS_SIZE_H = 3'd2;
    localparam logic [2:0] LS_SIZE_W = 3'd1;

    // Responses still owed to flushed instructions never exceed two.
    localparam logic [1:0] DROP_MAX = 2'd2;

    typedef enum logic [1:0] {
        MEM2_EMPTY = 2'd0,
        MEM2_READY = 2'd1,
        MEM2_WAIT  = 2'd2,
        MEM2_HAVE  = 2'd3
    } mem2_state_e;

    typedef struct packed {
        logic       inst_load;
        logic       inst_store;
        logic       ld_bh_sign;
        logic [2:0] ld_st_size;
    } mem_control_t;

    typedef struct packed {
        mem_control_t mem_control;
        logic [31:0]  exe_result;
        logic [4:0]   wb_wdest;
        logic         wb_we;
        logic [31:0]  pc;
    } mem12mem2_bus_t;

    typedef struct packed {
        logic [4:0]  wb_wdest;
        logic        wb_we;
        logic [31:0] wb_wdata;
        logic [31:0] pc;
    } mem22wb_bus_t;

    // Observation port so checkers can see the FSM and the response bookkeeping.
    typedef struct packed {
        mem2_state_e state;
        logic [1:0]  drop_cnt;
        logic        held_ls;
    } mem2_dbg_t;

    // Next value of the drop counter; increment and decrement in the same
    // cycle cancel, increment saturates at DROP_MAX.
    function automatic logic [1:0] drop_next(input logic [1:0] cur,
                                             input logic       inc,
                                             input logic       dec);
        logic [1:0] n;
        n = cur;
        if (inc && !dec) begin
            n = (cur == DROP_MAX) ? DROP_MAX : cur + 2'd1;
        end else if (dec && !inc) begin
            n = cur - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mem2_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a 32-bit word
// and sign- or zero-extends it. Word loads pass through untouched.
module mem2_load_align
    import mem2_pkg::*;
(
    input  logic [31:0] d,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  b;
    logic [15:0] h;

    // Shift the addressed lane down to bit 0, then extend according to size.
    always_comb begin
        byte_shift = d >> {off, 3'b000};
        half_shift = d >> {off[1], 4'b0000};
        b          = byte_shift[7:0];
        h          = half_shift[15:0];
        result     = d;
        case (size)
            LS_SIZE_B: result = {{24{sign & b[7]}}, b};
            LS_SIZE_H: result = {{16{sign & h[15]}}, h};
            default:   result = d;
        endcase
    end

endmodule

// File: rtl/mem2.sv
// Second memory stage. Holds one instruction from mem1, waits for the data-SRAM
// response of a load/store, aligns load data and presents the result to WB.
//
// Handshake: a stage "over" signal means the stage holds a finished result this
// cycle; the downstream "allowin" means it will take it at the next posedge.
// A transfer happens exactly when over && allowin are both high at a posedge,
// and an upstream stage may drop or change its offer only after such a transfer.
module mem2
    import mem2_pkg::*;
#(
    parameter int DW       = 32,
    parameter bit RESP_BYP = 1'b1
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MEM12MEM2_BUS_SIZE-1:0] mem12mem2_bus_i,
    input  logic                          ctl_mem1_over_i,
    output logic                          ctl_mem2_allowin_o,
    input  logic                          ctl_flush_i,
    input  logic                          data_sram_data_ok_i,
    input  logic [DW-1:0]                 data_sram_rdata_i,
    output logic [MEM22WB_BUS_SIZE-1:0]   mem22wb_bus_o,
    output logic                          ctl_mem2_over_o,
    input  logic                          ctl_wb_allowin_i,
    output logic [4:0]                    ctl_mem2_dest_o,
    output logic [DW-1:0]                 ctl_mem2_pc_o,
    output logic                          ctl_mem2_fwd_valid_o,
    output logic [DW-1:0]                 ctl_mem2_fwd_data_o,
    output mem2_dbg_t                     dbg_o
);

    mem12mem2_bus_t bus_in;
    mem12mem2_bus_t bus_q;
    mem2_state_e    state_q;
    logic           valid_q;
    logic [31:0]    rbuf_q;
    logic [1:0]     drop_q;

    logic        ls_in;
    logic        in_wait;
    logic        resp_take;
    logic        wait_open;
    logic        ready_go;
    logic        allowin;
    logic        latch_raw;
    logic        latch;
    logic        leave;
    logic        drop_inc;
    logic        drop_dec;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] wb_wdata;
    mem22wb_bus_t wb_bus;

    assign bus_in = mem12mem2_bus_i;
    assign ls_in  = bus_in.mem_control.inst_load | bus_in.mem_control.inst_store;

    // A response belongs to the held instruction only when nothing older is
    // still owed to a flushed access.
    assign in_wait   = valid_q && (state_q == MEM2_WAIT);
    assign resp_take = data_sram_data_ok_i && (drop_q == 2'd0);
    assign wait_open = in_wait && !resp_take;

    assign ready_go = valid_q && ((state_q == MEM2_READY) || (state_q == MEM2_HAVE) ||
                                  (in_wait && resp_take && RESP_BYP));
    assign allowin   = !valid_q || (ready_go && ctl_wb_allowin_i);
    assign latch_raw = allowin && ctl_mem1_over_i;
    assign latch     = latch_raw && !ctl_flush_i;
    assign leave     = ready_go && ctl_wb_allowin_i;

    // A flushed access whose response has not arrived yet must have that
    // response discarded later: either the one waiting here, or a load/store
    // mem1 hands over in the very cycle of the flush.
    assign drop_inc = ctl_flush_i && (wait_open || (latch_raw && ls_in));
    assign drop_dec = data_sram_data_ok_i && (drop_q != 2'd0);

    // Main FSM: occupancy, held bus and the load/store progress state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            state_q <= MEM2_EMPTY;
            bus_q   <= '0;
        end else if (ctl_flush_i) begin
            valid_q <= 1'b0;
            state_q <= MEM2_EMPTY;
        end else if (latch) begin
            valid_q <= 1'b1;
            bus_q   <= bus_in;
            state_q <= ls_in ? MEM2_WAIT : MEM2_READY;
        end else if (leave) begin
            valid_q <= 1'b0;
            state_q <= MEM2_EMPTY;
        end else if (in_wait && resp_take) begin
            state_q <= MEM2_HAVE;
        end
    end

    // Response bookkeeping: buffer the held access's data, count responses to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf_q <= '0;
            drop_q <= '0;
        end else begin
            drop_q <= drop_next(drop_q, drop_inc, drop_dec);
            if (in_wait && resp_take) begin
                rbuf_q <= data_sram_rdata_i;
            end
        end
    end

    // In HAVE the data comes from the buffer; otherwise it is the bypassed response.
    assign load_src = (state_q == MEM2_HAVE) ? rbuf_q : data_sram_rdata_i;

    mem2_load_align u_align (
        .d      (load_src),
        .off    (bus_q.exe_result[1:0]),
        .size   (bus_q.mem_control.ld_st_size),
        .sign   (bus_q.mem_control.ld_bh_sign),
        .result (load_data)
    );

    assign wb_wdata = bus_q.mem_control.inst_load ? load_data : bus_q.exe_result;

    assign wb_bus.wb_wdest = bus_q.wb_wdest;
    assign wb_bus.wb_we    = bus_q.wb_we;
    assign wb_bus.wb_wdata = wb_wdata;
    assign wb_bus.pc       = bus_q.pc;

    assign mem22wb_bus_o        = wb_bus;
    assign ctl_mem2_allowin_o   = allowin;
    assign ctl_mem2_over_o      = ready_go;
    assign ctl_mem2_dest_o      = valid_q ? bus_q.wb_wdest : 5'd0;
    assign ctl_mem2_pc_o        = bus_q.pc;
    assign ctl_mem2_fwd_valid_o = ready_go && bus_q.wb_we;
    assign ctl_mem2_fwd_data_o  = wb_wdata;

    assign dbg_o.state    = state_q;
    assign dbg_o.drop_cnt = drop_q;
    assign dbg_o.held_ls  = valid_q &&
                            (bus_q.mem_control.inst_load | bus_q.mem_control.inst_store);

endmodule
